// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states and datapath widths.
package alu_pkg;
   localparam int MUL_W = 16;
   localparam int ACC_W = 17;
   localparam int CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/parallel_adder.sv
// Plain ripple-carry adder; the carry out of the top bit is deliberately not produced.
module parallel_adder #(
   parameter int W = 17
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o
);
   logic [W-1:0] carry;

   assign carry[0] = cin_i;

   for (genvar gi = 0; gi < W; gi++) begin : g_bit
      assign sum_o[gi] = a_i[gi] ^ b_i[gi] ^ carry[gi];
      if (gi < W - 1) begin : g_carry
         assign carry[gi+1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
      end
   end
endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/sub + arithmetic shift per cycle, 16 steps.
module booth_seq_multiplier
   import alu_pkg::*;
#(
   parameter int WIDTH = MUL_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_W - 1);

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   m_q, m_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [MUL_W-1:0]   q_q, q_d;
   logic               q1_q, q1_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*MUL_W-1:0] prod_q, prod_d;
   logic               done_q, done_d;

   logic [1:0]         booth_pair;
   logic               do_sub;
   logic               do_op;
   logic [ACC_W-1:0]   add_b;
   logic [ACC_W-1:0]   add_sum;
   logic [ACC_W-1:0]   step_acc;

   // Booth recoding: 01 adds M, 10 subtracts M (as A + ~M + 1), 00/11 skip the adder.
   assign booth_pair = {q_q[0], q1_q};
   assign do_sub     = (booth_pair == 2'b10);
   assign do_op      = booth_pair[1] ^ booth_pair[0];
   assign add_b      = do_sub ? ~m_q : m_q;
   assign step_acc   = do_op ? add_sum : acc_q;

   parallel_adder #(.W(ACC_W)) u_adder (
      .a_i   (acc_q),
      .b_i   (add_b),
      .cin_i (do_sub),
      .sum_o (add_sum)
   );

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      acc_d   = acc_q;
      q_d     = q_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               m_d     = {a[MUL_W-1], a};
               acc_d   = '0;
               q_d     = b;
               q1_d    = 1'b0;
               cnt_d   = '0;
            end
         end
         RUN: begin
            acc_d = {step_acc[ACC_W-1], step_acc[ACC_W-1:1]};
            q_d   = {step_acc[0], q_q[MUL_W-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Two cycles in DONE: latch the product, then hold it while done pulses.
            if (!done_q) begin
               prod_d = {acc_q[MUL_W-1:0], q_q};
               done_d = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         m_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         cnt_q   <= '0;
         prod_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         done_q  <= done_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = done_q;
   assign product = prod_q;
endmodule
